// File: rtl/rv_alu_issue.sv
// Issue/writeback front end for rv_alu: decodes RV32I OP/OP-IMM, reads the register file, issues operands, writes the result back.
// Latency: accept -> ISSUE (1 cycle min) -> WAIT (until res_valid) -> WB (1 cycle); one instruction in flight at a time.
// Backpressure: instr_ready only in IDLE; alu_valid and operands are held until alu_ready; res_valid only counts in WAIT.
module rv_alu_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            alu_valid,
  input  logic            alu_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_ILL
  } state_t;

  state_t state_q, state_d;

  logic [3:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, res_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] regs_q [NREG];

  // Instruction fields
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;
  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  logic            is_op, is_imm, dec_legal, accept;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_sx, dec_b;

  // x0 always reads zero; its storage is never written
  assign rs1_val  = (rs1 == 5'd0) ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 5'd0) ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];
  assign imm_sx   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign accept   = (state_q == S_IDLE) && instr_valid;

  // Decode: legality, ALU op code (ADDI must never become SUB) and second operand
  always_comb begin
    is_op     = (opc == 7'b0110011);
    is_imm    = (opc == 7'b0010011);
    dec_legal = 1'b0;
    dec_op    = {1'b0, f3};
    dec_b     = imm_sx;
    if (is_op) begin
      dec_legal = (f7 == 7'b0000000) ||
                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
      dec_op    = {f7[5], f3};
      dec_b     = rs2_val;
    end else if (is_imm) begin
      case (f3)
        3'b001:  dec_legal = (f7 == 7'b0000000);
        3'b101:  dec_legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        default: dec_legal = 1'b1;
      endcase
      dec_op = {f7[5] & (f3 == 3'b101), f3};
    end
  end

  // State register
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_valid   = 1'b0;
    wb_valid    = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (accept) state_d = dec_legal ? S_ISSUE : S_ILL;
      end
      S_ISSUE: begin
        alu_valid = 1'b1;
        if (alu_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (res_valid) state_d = S_WB;
      end
      S_WB: begin
        wb_valid = 1'b1;
        state_d  = S_IDLE;
      end
      S_ILL: begin
        illegal = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch decoded operands on accept and the ALU result in WAIT
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      res_q <= '0;
    end else begin
      if (accept && dec_legal) begin
        op_q <= dec_op;
        a_q  <= rs1_val;
        b_q  <= dec_b;
        rd_q <= rd;
      end
      if ((state_q == S_WAIT) && res_valid) res_q <= res;
    end
  end

  // Register file write at the end of the WB cycle; rd=0 is discarded
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if ((state_q == S_WB) && (rd_q != 5'd0)) begin
      regs_q[rd_q] <= res_q;
    end
  end

  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign wb_rd   = rd_q;
  assign wb_data = res_q;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Bench for rv_alu_issue: directed cases followed by random OP/OP-IMM/garbage words.
// The bench acts as the ALU and keeps its own register-file model.
// Outputs are sampled on the falling edge; inputs change on the falling edge or just after the rising edge.
module tb_rv_alu_issue;

  logic        clkin = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic        alu_valid;
  logic        alu_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        res_valid = 1'b0;
  logic [31:0] res = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] mregs [32];

  rv_alu_issue #(.XLEN(32), .NREG(32)) dut (
    .clkin(clkin), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b),
    .res_valid(res_valid), .res(res),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---- reference model, written from the ISA rules ----
  function automatic bit m_legal(input logic [31:0] w);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    if (opc == 7'h33) return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    if (opc == 7'h13) begin
      if (f3 == 3'd1) return f7 == 7'h00;
      if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_reg(input logic [4:0] r);
    return (r == 5'd0) ? 32'd0 : mregs[r];
  endfunction

  function automatic logic [3:0] m_op(input logic [31:0] w);
    logic [2:0] f3;
    f3 = w[14:12];
    if (w[6:0] == 7'h33) return {w[30], f3};
    return {(f3 == 3'd5) ? w[30] : 1'b0, f3};
  endfunction

  function automatic logic [31:0] m_b(input logic [31:0] w);
    if (w[6:0] == 7'h33) return m_reg(w[24:20]);
    return {{20{w[31]}}, w[31:20]};
  endfunction

  // The ALU the bench plays: RV32I semantics of the 4-bit op code
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op[2:0])
      3'd0: return op[3] ? a - b : a + b;
      3'd1: return a << sh;
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return op[3] ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // One complete instruction with `stall` cycles of alu_ready low and `rdly` cycles before res_valid
  task automatic do_instr(input logic [31:0] w, input int stall, input int rdly);
    logic [3:0]  eop, dop;
    logic [31:0] ea, eb, eres, da, db;
    logic [4:0]  rd;
    rd  = w[11:7];
    eop = m_op(w);
    ea  = m_reg(w[19:15]);
    eb  = m_b(w);
    @(negedge clkin);
    chk("instr_ready", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr = w;
    @(posedge clkin); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    @(negedge clkin);
    if (!m_legal(w)) begin
      chk("illegal_pulse", {31'd0, illegal}, 32'd1);
      chk("illegal_no_issue", {31'd0, alu_valid}, 32'd0);
      @(negedge clkin);
      chk("illegal_end", {31'd0, illegal}, 32'd0);
      chk("illegal_alu_valid", {31'd0, alu_valid}, 32'd0);
      return;
    end
    chk("legal_no_illegal", {31'd0, illegal}, 32'd0);
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, alu_valid}, 32'd1);
      chk("stall_op", {28'd0, alu_op}, {28'd0, eop});
      chk("stall_a", alu_a, ea);
      chk("stall_b", alu_b, eb);
      res_valid = 1'b1;                // stray strobe outside WAIT must be ignored
      res = $urandom;
      @(negedge clkin);
    end
    res_valid = 1'b0;
    chk("issue_valid", {31'd0, alu_valid}, 32'd1);
    chk("issue_op", {28'd0, alu_op}, {28'd0, eop});
    chk("issue_a", alu_a, ea);
    chk("issue_b", alu_b, eb);
    dop = alu_op; da = alu_a; db = alu_b;
    alu_ready = 1'b1;
    @(posedge clkin); #1;
    alu_ready = 1'b0;
    @(negedge clkin);
    chk("wait_valid_low", {31'd0, alu_valid}, 32'd0);
    for (int i = 0; i < rdly; i++) begin
      chk("wait_no_wb", {31'd0, wb_valid}, 32'd0);
      @(negedge clkin);
    end
    res_valid = 1'b1;
    res = alu_fn(dop, da, db);
    eres = alu_fn(eop, ea, eb);
    @(posedge clkin); #1;
    res_valid = 1'b0;
    @(negedge clkin);
    chk("wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
    chk("wb_data", wb_data, eres);
    if (rd != 5'd0) mregs[rd] = eres;
    @(negedge clkin);
    chk("wb_pulse_end", {31'd0, wb_valid}, 32'd0);
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, m_reg(rd));
  endtask

  // Start an instruction and stop once it is in ISSUE (at a falling edge)
  task automatic start_issue(input logic [31:0] w);
    @(negedge clkin);
    instr_valid = 1'b1;
    instr = w;
    @(posedge clkin); #1;
    instr_valid = 1'b0;
    @(negedge clkin);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
    chk({tag, "_alu_valid"}, {31'd0, alu_valid}, 32'd0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    chk({tag, "_alu_a"}, alu_a, 32'd0);
    chk({tag, "_wb_data"}, wb_data, 32'd0);
  endtask

  task automatic sweep_regs(input string tag);
    for (int r = 0; r < 32; r++) begin
      dbg_addr = r[4:0];
      #1;
      chk(tag, dbg_data, m_reg(r[4:0]));
    end
  endtask

  initial begin
    logic [31:0] w, imm;
    logic [6:0]  f7;
    int sel;
    for (int r = 0; r < 32; r++) mregs[r] = '0;

    // Reset state
    #2;
    check_reset_outputs("reset");
    @(negedge clkin);
    rst = 1'b0;

    // ADDI x1,x0,5
    do_instr(32'h00500093, 0, 0);
    dbg_addr = 5'd1; #1;
    chk("x1_is_5", dbg_data, 32'd5);
    // ADD x2,x1,x1 with three stalled cycles
    do_instr(32'h00108133, 3, 0);
    dbg_addr = 5'd2; #1;
    chk("x2_is_10", dbg_data, 32'd10);
    // SRAI x3,x2,1
    do_instr(32'h40115193, 0, 1);
    // SUB x4,x2,x1
    do_instr(32'h40110233, 1, 2);
    // Illegal words leave the register file alone
    do_instr(32'h0000007F, 0, 0);
    do_instr(32'h40009093, 0, 0);
    sweep_regs("regs_after_illegal");
    // ADDI x0,x0,7
    do_instr(32'h00700013, 0, 0);
    dbg_addr = 5'd0; #1;
    chk("x0_reads_0", dbg_data, 32'd0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      w = '0;
      w[11:7]  = 5'($urandom_range(0, 7));
      w[14:12] = 3'($urandom_range(0, 7));
      w[19:15] = 5'($urandom_range(0, 7));
      w[24:20] = 5'($urandom_range(0, 7));
      if (sel < 4) begin
        w[6:0] = 7'h33;
        f7 = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
        w[31:25] = f7;
      end else if (sel < 8) begin
        w[6:0] = 7'h13;
        imm = $urandom;
        w[31:20] = imm[11:0];
        if ($urandom_range(0, 1) == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
      end else if (sel == 8) begin
        w = $urandom;
      end else begin
        w[6:0] = 7'h33;
        w[31:25] = 7'($urandom);
      end
      do_instr(w, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    sweep_regs("regs_after_random");

    // Reset in the middle of ISSUE drops alu_valid at once
    start_issue(32'h00108133);
    chk("pre_rst_issue", {31'd0, alu_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_issue");
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    @(negedge clkin);
    rst = 1'b0;

    // Reset in WAIT: no writeback and a late res_valid is ignored
    do_instr(32'h00500093, 0, 0);
    start_issue(32'h00108133);
    alu_ready = 1'b1;
    @(posedge clkin); #1;
    alu_ready = 1'b0;
    @(negedge clkin);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("rst_in_wait");
    for (int r = 0; r < 32; r++) mregs[r] = '0;
    @(negedge clkin);
    rst = 1'b0;
    res_valid = 1'b1;
    res = 32'h1234;
    @(posedge clkin); #1;
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkin);
      chk("late_res_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("late_res_ready", {31'd0, instr_ready}, 32'd1);
    end
    sweep_regs("regs_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
